pipe_stage_reg: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake, stall and flush.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_stage_reg_register.sv | 22 ++
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: state encodings and count width.
package pipe_pkg;

   localparam int unsigned CNT_W = 2;

   // Entries held by the stage; the count output is the state itself.
   localparam logic [CNT_W-1:0] ST_EMPTY = 2'd0;
   localparam logic [CNT_W-1:0] ST_ONE   = 2'd1;
   localparam logic [CNT_W-1:0] ST_BOTH  = 2'd2;

endpackage

// File: rtl/pipe_stage_reg_register.sv
// Enable-gated storage register with asynchronous active-low reset to RST_VAL.
module Register #(
   parameter int unsigned  N       = 32,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Load d when enabled; reset returns the register to RST_VAL immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, stall and flush.
// SKID=1 adds a second entry so in_ready comes straight from registered state.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned  N       = 32,
   parameter logic [N-1:0] RST_VAL = '0,
   parameter bit           SKID    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] state_q, state_d;
   logic             acc, drn;
   logic             main_en, main_from_skid;
   logic [N-1:0]     main_d, main_q, skid_q;

   assign out_valid = (state_q != ST_EMPTY);
   assign count     = state_q;
   assign out_data  = main_q;
   assign acc       = in_valid & in_ready;
   assign drn       = out_valid & out_ready;

   generate
      if (SKID) begin : g_ready_reg
         assign in_ready = (state_q != ST_BOTH);
      end else begin : g_ready_comb
         assign in_ready = !out_valid | out_ready;
      end
   endgenerate

   // Next-state and main-register load decode; flush overrides any transfer.
   always_comb begin
      state_d        = state_q;
      main_en        = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
         main_en = 1'b1;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d = ST_ONE;
                  main_en = 1'b1;
               end
            end
            ST_ONE: begin
               // Without a skid entry acc implies drn here, so both cases reload main.
               if (acc && (drn || !SKID)) begin
                  main_en = 1'b1;
               end else if (acc) begin
                  state_d = ST_BOTH;
               end else if (drn) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_BOTH: begin
               if (drn) begin
                  state_d        = ST_ONE;
                  main_en        = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign main_d = flush ? RST_VAL : (main_from_skid ? skid_q : in_data);

   // State register; reset empties the stage at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   Register #(.N(N), .RST_VAL(RST_VAL)) u_main (
      .clk   (clk),
      .reset (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (main_q)
   );

   generate
      if (SKID) begin : g_skid
         logic         skid_en;
         logic [N-1:0] skid_d;
         // The skid entry only fills when an accept meets a stalled output.
         assign skid_en = flush | ((state_q == ST_ONE) & acc & ~drn);
         assign skid_d  = flush ? RST_VAL : in_data;
         Register #(.N(N), .RST_VAL(RST_VAL)) u_skid (
            .clk   (clk),
            .reset (reset),
            .en    (skid_en),
            .d     (skid_d),
            .q     (skid_q)
         );
      end else begin : g_no_skid
         assign skid_q = RST_VAL;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance side by side.
module tb_pipe_stage_reg;

   localparam int unsigned N       = 32;
   localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [1:0]  in_valid;
   logic [1:0]  in_ready;
   logic [1:0]  out_valid;
   logic [1:0]  out_ready;
   logic [31:0] in_data  [2];
   logic [31:0] out_data [2];
   logic [1:0]  count    [2];
   logic [1:0]  acc_seen;

   int compared = 0;
   int errors   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.N(N), .RST_VAL(RST_VAL), .SKID(1'b1)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_data   (in_data[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_data  (out_data[0]),
      .count     (count[0])
   );

   pipe_stage_reg #(.N(N), .RST_VAL(RST_VAL), .SKID(1'b0)) u_noskid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_data   (in_data[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_data  (out_data[1]),
      .count     (count[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: push on accept, pop and compare on drain, sampled at negedge.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      logic [31:0] sb [$];
      logic        hold_v = 1'b0;
      logic [31:0] hold_d = '0;
      int unsigned depth  = 0;
      always @(negedge clk) begin
         if (!reset) begin
            sb.delete();
            hold_v = 1'b0;
         end else begin
            if (hold_v && out_valid[g]) chk("stall_hold", out_data[g], hold_d);
            hold_v = out_valid[g] && !out_ready[g] && !flush;
            hold_d = out_data[g];
            chk("valid_vs_count", out_valid[g], count[g] != 2'd0);
            if (out_valid[g] && out_ready[g]) begin
               if (sb.size() == 0) begin
                  compared++;
                  errors++;
                  $display("FAIL unexpected_output: got %h, scoreboard empty (t=%0t)", out_data[g], $time);
               end else begin
                  chk("out_data", out_data[g], sb.pop_front());
               end
            end
            if (in_valid[g] && in_ready[g] && !flush) sb.push_back(in_data[g]);
            if (flush) sb.delete();
         end
         depth = sb.size();
      end
   end

   // Ready/count invariants for each configuration.
   always @(negedge clk) begin
      if (reset) begin
         chk("skid_ready_from_state", in_ready[0], count[0] != 2'd2);
         chk("noskid_ready", in_ready[1], !out_valid[1] | out_ready[1]);
         chk("noskid_count_le_1", count[1] <= 2'd1, 1'b1);
      end
   end

   task automatic tick();
      @(negedge clk);
      acc_seen = in_valid & in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_out_valid"}, out_valid[i], 1'b0);
         chk({tag, "_count"}, count[i], 2'd0);
         chk({tag, "_in_ready"}, in_ready[i], 1'b1);
         chk({tag, "_out_data"}, out_data[i], RST_VAL);
      end
   endtask

   initial begin
      int          acc_cnt [2];
      int unsigned nxt [2];
      in_valid  = '0;
      out_ready = '0;
      in_data[0] = '0;
      in_data[1] = '0;
      acc_seen  = '0;

      // Power-up reset, checked before any clock edge.
      #1 reset = 1'b0;
      #1 chk_reset_state("por");
      @(posedge clk);
      #1 reset = 1'b1;

      // Streaming 1..100 on both instances at full rate.
      acc_cnt = '{0, 0};
      in_data[0] = 32'd1;
      in_data[1] = 32'd1;
      in_valid   = '1;
      out_ready  = '1;
      for (int c = 0; c < 100; c++) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            if (acc_seen[i]) begin
               acc_cnt[i]++;
               in_data[i] = in_data[i] + 32'd1;
            end
         end
      end
      chk("stream_rate_skid", acc_cnt[0], 100);
      chk("stream_rate_noskid", acc_cnt[1], 100);
      in_valid = '0;
      repeat (3) tick();
      chk("stream_drained_skid", g_mon[0].depth, 0);
      chk("stream_drained_noskid", g_mon[1].depth, 0);

      // Backpressure on the skid instance: 0xA then 0xB fill both entries.
      out_ready  = '0;
      in_valid   = 2'b01;
      in_data[0] = 32'hA;
      tick();
      chk("bp_acc_a", acc_seen[0], 1'b1);
      in_data[0] = 32'hB;
      tick();
      chk("bp_acc_b", acc_seen[0], 1'b1);
      in_valid = '0;
      chk("bp_count2", count[0], 2'd2);
      chk("bp_in_ready0", in_ready[0], 1'b0);
      chk("bp_head_a", out_data[0], 32'hA);
      out_ready = 2'b01;
      tick();
      chk("bp_count1", count[0], 2'd1);
      chk("bp_head_b", out_data[0], 32'hB);
      tick();
      chk("bp_count0", count[0], 2'd0);
      chk("bp_out_valid0", out_valid[0], 1'b0);

      // Flush with the skid instance full and 0xC offered; empty no-skid instance offered 0xD.
      out_ready  = '0;
      in_valid   = 2'b01;
      in_data[0] = 32'hA;
      tick();
      in_data[0] = 32'hB;
      tick();
      chk("fl_full", count[0], 2'd2);
      in_data[0] = 32'hC;
      in_data[1] = 32'hD;
      in_valid   = 2'b11;
      flush      = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = '0;
      chk("fl_d_offered_ready", acc_seen[1], 1'b1);
      chk_reset_state("flush");
      out_ready = '1;
      repeat (3) tick();
      chk("fl_no_c_skid", out_valid[0], 1'b0);
      chk("fl_no_d_noskid", out_valid[1], 1'b0);
      chk("fl_sb_skid", g_mon[0].depth, 0);
      chk("fl_sb_noskid", g_mon[1].depth, 0);

      // Random valid/ready/flush traffic with an asynchronous reset midway.
      nxt = '{32'h1000, 32'h8000};
      for (int c = 0; c < 4000; c++) begin
         if (c == 2000) begin
            #2 reset = 1'b0;
            #1 chk_reset_state("mid_reset");
            in_valid = '0;
            flush    = 1'b0;
            acc_seen = '0;
            @(negedge clk);
            @(posedge clk);
            #1 reset = 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            if (!in_valid[i] || acc_seen[i]) begin
               in_valid[i] = ($urandom_range(0, 3) != 0);
               in_data[i]  = nxt[i];
               nxt[i]++;
            end
            out_ready[i] = ($urandom_range(0, 1) != 0);
         end
         flush = ($urandom_range(0, 63) == 0);
         tick();
      end
      in_valid  = '0;
      flush     = 1'b0;
      out_ready = '1;
      repeat (4) tick();
      chk("rand_drained_skid", g_mon[0].depth, 0);
      chk("rand_drained_noskid", g_mon[1].depth, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
      $finish;
   end

endmodule
